// File: rtl/data_mem_lsu.sv
// Word-organised data memory behind a single-outstanding load/store port.
// Byte/halfword/word accesses, configurable wait states, one-cycle response.
module data_mem_lsu #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_UNSIGNED,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR
);

  localparam int DEPTH = 2**(ADDR_W-2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic              r_we;
  logic              r_uns;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [31:0]       r_wdata;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [31:0]       r_mem [DEPTH] = '{default: '0};

  logic              w_idle;
  logic              w_go;
  logic              w_we;
  logic              w_uns;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_size;
  logic [31:0]       w_wdata;
  logic              w_err;
  logic [ADDR_W-3:0] w_idx;
  logic [31:0]       w_word;
  logic [7:0]        w_b;
  logic [15:0]       w_h;
  logic [31:0]       w_load;
  logic [3:0]        w_be;
  logic [31:0]       w_wlane;

  assign w_idle = (r_state == S_IDLE);

  // With no wait states the access completes on the accept edge itself,
  // so the live request fields are used instead of the latched copies.
  assign w_go = (w_idle && REQ_VALID && WAIT_STATES == 0)
             || (r_state == S_WAIT && r_cnt == 3'd0);

  assign w_we    = w_idle ? REQ_WE       : r_we;
  assign w_uns   = w_idle ? REQ_UNSIGNED : r_uns;
  assign w_addr  = w_idle ? REQ_ADDR     : r_addr;
  assign w_size  = w_idle ? REQ_SIZE     : r_size;
  assign w_wdata = w_idle ? REQ_WDATA    : r_wdata;

  assign w_err = (w_size == 2'b11)
              || (w_size == 2'b01 && w_addr[0])
              || (w_size == 2'b10 && w_addr[1:0] != 2'b00);

  assign w_idx  = w_addr[ADDR_W-1:2];
  assign w_word = r_mem[w_idx];
  assign w_b    = w_word[{w_addr[1:0], 3'b000} +: 8];
  assign w_h    = w_word[{w_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load = w_word;
    case (w_size)
      2'b00:   w_load = w_uns ? {24'd0, w_b} : {{24{w_b[7]}}, w_b};
      2'b01:   w_load = w_uns ? {16'd0, w_h} : {{16{w_h[15]}}, w_h};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = w_wdata;
    case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wlane = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // Memory has no reset; reset only blocks a pending commit.
  always_ff @(posedge CLK) begin
    if (!RST && w_go && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wlane[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (REQ_VALID) begin
            r_we    <= REQ_WE;
            r_uns   <= REQ_UNSIGNED;
            r_addr  <= REQ_ADDR;
            r_size  <= REQ_SIZE;
            r_wdata <= REQ_WDATA;
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 3'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_go) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || w_we) ? 32'd0 : w_load;
      end
    end
  end

  assign REQ_READY = w_idle;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;
  assign RSP_ERR   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: three instances with 0, 2 and 3
// wait states share one clock; expected responses are queued at issue.
module tb_data_mem_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       rv;
  logic [2:0]       rwe;
  logic [2:0]       runs;
  logic [2:0]       rdy;
  logic [2:0]       vld;
  logic [2:0]       err;
  logic [2:0][9:0]  raddr;
  logic [2:0][1:0]  rsize;
  logic [2:0][31:0] rwd;
  logic [2:0][31:0] rdat;

  data_mem_lsu #(.ADDR_W(10), .WAIT_STATES(0)) u_d0 (
    .CLK(clk), .RST(rst[0]), .REQ_VALID(rv[0]), .REQ_READY(rdy[0]),
    .REQ_WE(rwe[0]), .REQ_ADDR(raddr[0]), .REQ_SIZE(rsize[0]),
    .REQ_UNSIGNED(runs[0]), .REQ_WDATA(rwd[0]), .RSP_VALID(vld[0]),
    .RSP_RDATA(rdat[0]), .RSP_ERR(err[0]));

  data_mem_lsu #(.ADDR_W(10), .WAIT_STATES(2)) u_d2 (
    .CLK(clk), .RST(rst[1]), .REQ_VALID(rv[1]), .REQ_READY(rdy[1]),
    .REQ_WE(rwe[1]), .REQ_ADDR(raddr[1]), .REQ_SIZE(rsize[1]),
    .REQ_UNSIGNED(runs[1]), .REQ_WDATA(rwd[1]), .RSP_VALID(vld[1]),
    .RSP_RDATA(rdat[1]), .RSP_ERR(err[1]));

  data_mem_lsu #(.ADDR_W(10), .WAIT_STATES(3)) u_d3 (
    .CLK(clk), .RST(rst[2]), .REQ_VALID(rv[2]), .REQ_READY(rdy[2]),
    .REQ_WE(rwe[2]), .REQ_ADDR(raddr[2]), .REQ_SIZE(rsize[2]),
    .REQ_UNSIGNED(runs[2]), .REQ_WDATA(rwd[2]), .RSP_VALID(vld[2]),
    .RSP_RDATA(rdat[2]), .RSP_ERR(err[2]));

  typedef struct {
    int          k;
    logic [31:0] rd;
    logic        er;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic [7:0] mm [1024] = '{default: '0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int ws(int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 3;
  endfunction

  // Byte-array reference of the little-endian memory.
  function automatic void model(bit we, logic [9:0] a, logic [1:0] sz,
                                bit u, logic [31:0] wd,
                                output logic [31:0] rd, output bit er);
    int n;
    logic [31:0] v;
    er = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
         (sz == 2'd2 && a[1:0] != 2'd0);
    rd = 32'd0;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (er) return;
    if (we) begin
      for (int i = 0; i < n; i++) mm[int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mm[int'(a) + i];
      if (n == 1)      rd = u ? v : {{24{v[7]}}, v[7:0]};
      else if (n == 2) rd = u ? v : {{16{v[15]}}, v[15:0]};
      else             rd = v;
    end
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (vld[k]) begin
          if (sb.size() == 0) begin
            check("unexp_rsp", 64'(vld[k]), 64'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_inst", 64'(k), 64'(e.k));
            check("rsp_cyc", 64'(cyc), 64'(e.cyc));
            check("rsp_rdata", 64'(rdat[k]), 64'(e.rd));
            check("rsp_err", 64'(err[k]), 64'(e.er));
          end
        end else begin
          check("idle_zero", {31'd0, err[k], rdat[k]}, 64'd0);
        end
      end
    end
  end

  task automatic drive(int k, bit we, logic [9:0] a, logic [1:0] sz,
                       bit u, logic [31:0] wd);
    rv[k]    = 1'b1;
    rwe[k]   = we;
    raddr[k] = a;
    rsize[k] = sz;
    runs[k]  = u;
    rwd[k]   = wd;
  endtask

  task automatic push_exp(int k, logic [31:0] xrd, bit xer);
    exp_t e;
    e.k   = k;
    e.rd  = xrd;
    e.er  = xer;
    e.cyc = cyc + 1 + ws(k);
    sb.push_back(e);
  endtask

  task automatic wait_drain(string tag);
    int guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      check(tag, 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Called at a negedge; returns at a negedge once the response is seen.
  task automatic issue(int k, bit we, logic [9:0] a, logic [1:0] sz,
                       bit u, logic [31:0] wd,
                       logic [31:0] xrd, bit xer);
    int guard = 0;
    while (!rdy[k] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_issue", 64'(rdy[k]), 64'd1);
    drive(k, we, a, sz, u, wd);
    push_exp(k, xrd, xer);
    @(posedge clk);
    @(negedge clk);
    rv[k] = 1'b0;
    wait_drain("rsp_timeout");
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] xrd;
    bit          xer;
    bit          we;
    bit          u;
    logic [9:0]  a;
    logic [1:0]  sz;
    logic [31:0] wd;

    rst   = 3'b111;
    rv    = 3'b000;
    rwe   = 3'b000;
    runs  = 3'b000;
    raddr = '0;
    rsize = '0;
    rwd   = '0;

    // A request presented while reset is high must be ignored.
    drive(0, 1'b1, 10'h030, 2'd2, 1'b0, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(rdy), 64'd7);
    check("rst_valid", 64'(vld), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdata0", 64'(rdat[0]), 64'd0);
    rv[0]  = 1'b0;
    rst    = 3'b000;
    mon_en = 1'b1;
    @(negedge clk);

    issue(0, 1'b0, 10'h030, 2'd2, 1'b0, 32'd0, 32'h0000_0000, 1'b0);

    issue(0, 1'b1, 10'h010, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0);
    issue(0, 1'b0, 10'h010, 2'd2, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0);

    issue(0, 1'b1, 10'h011, 2'd0, 1'b0, 32'hFFFF_FF80, 32'd0, 1'b0);
    issue(0, 1'b0, 10'h011, 2'd0, 1'b0, 32'd0, 32'hFFFF_FF80, 1'b0);
    issue(0, 1'b0, 10'h011, 2'd0, 1'b1, 32'd0, 32'h0000_0080, 1'b0);
    issue(0, 1'b0, 10'h010, 2'd2, 1'b1, 32'd0, 32'hDEAD_80EF, 1'b0);

    issue(0, 1'b0, 10'h013, 2'd1, 1'b0, 32'd0, 32'd0, 1'b1);
    issue(0, 1'b1, 10'h012, 2'd2, 1'b0, 32'h1111_1111, 32'd0, 1'b1);
    issue(0, 1'b0, 10'h010, 2'd2, 1'b0, 32'd0, 32'hDEAD_80EF, 1'b0);
    issue(0, 1'b0, 10'h010, 2'd3, 1'b0, 32'd0, 32'd0, 1'b1);
    issue(0, 1'b1, 10'h010, 2'd3, 1'b0, 32'h2222_2222, 32'd0, 1'b1);
    issue(0, 1'b0, 10'h010, 2'd2, 1'b0, 32'd0, 32'hDEAD_80EF, 1'b0);

    issue(0, 1'b1, 10'h016, 2'd1, 1'b0, 32'hABCD_1234, 32'd0, 1'b0);
    issue(0, 1'b0, 10'h014, 2'd2, 1'b0, 32'd0, 32'h1234_0000, 1'b0);
    issue(0, 1'b1, 10'h014, 2'd1, 1'b0, 32'h0000_8001, 32'd0, 1'b0);
    issue(0, 1'b0, 10'h014, 2'd1, 1'b0, 32'd0, 32'hFFFF_8001, 1'b0);
    issue(0, 1'b0, 10'h014, 2'd1, 1'b1, 32'd0, 32'h0000_8001, 1'b0);
    issue(0, 1'b0, 10'h016, 2'd1, 1'b0, 32'd0, 32'h0000_1234, 1'b0);
    issue(0, 1'b0, 10'h014, 2'd2, 1'b0, 32'd0, 32'h1234_8001, 1'b0);
    issue(0, 1'b1, 10'h017, 2'd0, 1'b0, 32'h0000_00C3, 32'd0, 1'b0);
    issue(0, 1'b0, 10'h017, 2'd0, 1'b0, 32'd0, 32'hFFFF_FFC3, 1'b0);
    issue(0, 1'b0, 10'h014, 2'd2, 1'b1, 32'd0, 32'hC334_8001, 1'b0);

    // Random traffic against the byte model in an untouched region.
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      a  = 10'h100 + 10'($urandom_range(0, 15));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      model(we, a, sz, u, wd, xrd, xer);
      issue(0, we, a, sz, u, wd, xrd, xer);
    end

    // Three wait states; valid stays high through the wait.
    drive(2, 1'b1, 10'h040, 2'd2, 1'b0, 32'hA5A5_A5A5);
    push_exp(2, 32'd0, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ws3_ready_low", 64'(rdy[2]), 64'd0);
      check("ws3_valid", 64'(vld[2]), 64'(i == 3));
      if (i == 0) drive(2, 1'b0, 10'h044, 2'd2, 1'b0, 32'd0);
      if (i == 3) rv[2] = 1'b0;
    end
    @(negedge clk);
    check("ws3_ready_back", 64'(rdy[2]), 64'd1);
    repeat (6) @(negedge clk);
    check("ws3_no_second", 64'(sb.size()), 64'd0);
    issue(2, 1'b0, 10'h040, 2'd2, 1'b0, 32'd0, 32'hA5A5_A5A5, 1'b0);
    issue(2, 1'b0, 10'h041, 2'd0, 1'b1, 32'd0, 32'h0000_00A5, 1'b0);

    // Reset lands on the commit edge of a two-wait-state store.
    issue(1, 1'b0, 10'h020, 2'd2, 1'b0, 32'd0, 32'h0000_0000, 1'b0);
    drive(1, 1'b1, 10'h020, 2'd2, 1'b0, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    rv[1] = 1'b0;
    check("abort_wait_ready", 64'(rdy[1]), 64'd0);
    @(negedge clk);
    check("abort_pre_valid", 64'(vld[1]), 64'd0);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    check("abort_valid", 64'(vld[1]), 64'd0);
    check("abort_ready", 64'(rdy[1]), 64'd1);
    issue(1, 1'b0, 10'h020, 2'd2, 1'b0, 32'd0, 32'h0000_0000, 1'b0);
    issue(1, 1'b1, 10'h020, 2'd2, 1'b0, 32'h1234_5678, 32'd0, 1'b0);
    issue(1, 1'b0, 10'h022, 2'd1, 1'b0, 32'd0, 32'h0000_1234, 1'b0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
